// File: rtl/bist_march_ctrl_if.sv
// rtl/bist_march_ctrl_if.sv - start/status and SRAM-side signals of the March C- BIST sequencer
interface bist_march_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4
);
  logic                  start;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ce;
  logic                  mem_we;
  logic [1:0]            pat_sel;
  logic                  busy;
  logic                  done;
  logic                  fail;
  logic [ADDR_WIDTH-1:0] fail_addr;

  modport master (
    output start, mem_rdata,
    input  mem_addr, mem_ce, mem_we, pat_sel, busy, done, fail, fail_addr
  );

  modport slave (
    input  start, mem_rdata,
    output mem_addr, mem_ce, mem_we, pat_sel, busy, done, fail, fail_addr
  );
endinterface

// File: rtl/bist_march_ctrl.sv
// rtl/bist_march_ctrl.sv - March C- BIST sequencer: two data backgrounds, registered SRAM controls,
// one-cycle read compare pipeline with sticky fail and first failing address.
module bist_march_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bist_march_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [2:0]            ELEM_LAST = 3'd5;

  state_t                r_state;
  logic                  r_bg;
  logic [2:0]            r_elem;
  logic                  r_phase;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic                  r_cmp_valid;
  logic [ADDR_WIDTH-1:0] r_cmp_addr;
  logic [DATA_WIDTH-1:0] r_cmp_exp;

  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_ce;
  logic                  r_mem_we;
  logic [1:0]            r_pat_sel;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_fail;
  logic [ADDR_WIDTH-1:0] r_fail_addr;

  logic                  w_nxt_bg;
  logic [2:0]            w_nxt_elem;
  logic                  w_nxt_phase;
  logic [ADDR_WIDTH-1:0] w_nxt_addr;
  logic                  w_last_op;
  logic                  w_end_addr;

  // Element table: M0 w0 | M1 r0,w1 | M2 r1,w0 | M3 r0,w1 | M4 r1,w0 | M5 r0
  function automatic logic op_we(input logic [2:0] e, input logic p);
    return (e == 3'd0) ? 1'b1 : p;
  endfunction

  function automatic logic op_inv(input logic [2:0] e, input logic p);
    case (e)
      3'd1, 3'd3: return p;
      3'd2, 3'd4: return ~p;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic is_last_phase(input logic [2:0] e, input logic p);
    return (e == 3'd0 || e == ELEM_LAST) ? 1'b1 : p;
  endfunction

  function automatic logic is_down(input logic [2:0] e);
    return (e >= 3'd3);
  endfunction

  // Background 0 is all-zero, background 1 is alternating ...0101.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic bg, input logic inv);
    logic [DATA_WIDTH-1:0] p;
    for (int i = 0; i < DATA_WIDTH; i++) p[i] = bg & (i % 2 == 0);
    return inv ? ~p : p;
  endfunction

  always_comb begin
    w_nxt_bg    = r_bg;
    w_nxt_elem  = r_elem;
    w_nxt_phase = r_phase;
    w_nxt_addr  = r_addr;
    w_last_op   = 1'b0;
    w_end_addr  = is_down(r_elem) ? (r_addr == '0) : (r_addr == ADDR_MAX);
    if (!is_last_phase(r_elem, r_phase)) begin
      w_nxt_phase = 1'b1;
    end else begin
      w_nxt_phase = 1'b0;
      if (!w_end_addr) begin
        w_nxt_addr = is_down(r_elem) ? r_addr - 1'b1 : r_addr + 1'b1;
      end else if (r_elem != ELEM_LAST) begin
        w_nxt_elem = r_elem + 3'd1;
        w_nxt_addr = is_down(r_elem + 3'd1) ? ADDR_MAX : '0;
      end else if (!r_bg) begin
        w_nxt_bg   = 1'b1;
        w_nxt_elem = 3'd0;
        w_nxt_addr = '0;
      end else begin
        w_last_op = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bg        <= 1'b0;
      r_elem      <= 3'd0;
      r_phase     <= 1'b0;
      r_addr      <= '0;
      r_cmp_valid <= 1'b0;
      r_cmp_addr  <= '0;
      r_cmp_exp   <= '0;
      r_mem_addr  <= '0;
      r_mem_ce    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_pat_sel   <= 2'b00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
    end else begin
      // Read data returns one cycle after issue; capture what it must match now.
      r_cmp_valid <= r_mem_ce & ~r_mem_we;
      r_cmp_addr  <= r_mem_addr;
      r_cmp_exp   <= pattern(r_pat_sel[1], r_pat_sel[0]);
      if (r_cmp_valid && (bus.mem_rdata != r_cmp_exp)) begin
        r_fail <= 1'b1;
        if (!r_fail) r_fail_addr <= r_cmp_addr;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_bg        <= 1'b0;
            r_elem      <= 3'd0;
            r_phase     <= 1'b0;
            r_addr      <= '0;
            r_mem_addr  <= '0;
            r_mem_ce    <= 1'b1;
            r_mem_we    <= 1'b1;
            r_pat_sel   <= 2'b00;
          end
        end
        S_RUN: begin
          if (w_last_op) begin
            r_state   <= S_FLUSH;
            r_mem_ce  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_pat_sel <= 2'b00;
          end else begin
            r_bg       <= w_nxt_bg;
            r_elem     <= w_nxt_elem;
            r_phase    <= w_nxt_phase;
            r_addr     <= w_nxt_addr;
            r_mem_addr <= w_nxt_addr;
            r_mem_we   <= op_we(w_nxt_elem, w_nxt_phase);
            r_pat_sel  <= {w_nxt_bg, op_inv(w_nxt_elem, w_nxt_phase)};
          end
        end
        S_FLUSH: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_ce    = r_mem_ce;
  assign bus.mem_we    = r_mem_we;
  assign bus.pat_sel   = r_pat_sel;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.fail      = r_fail;
  assign bus.fail_addr = r_fail_addr;

endmodule

// File: tb/tb_bist_march_ctrl.sv
// tb/tb_bist_march_ctrl.sv - bench for bist_march_ctrl: faulty SRAM model behind the background mux,
// March C- op list and expected verdict computed from the algorithm table.
module tb_bist_march_ctrl;
  localparam int AW = 8;
  localparam int DW = 4;
  localparam int N  = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] a;
    logic          we;
    logic [1:0]    ps;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bist_march_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  bist_march_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic          sa0_en = 1'b0, sa1_en = 1'b0, cf_en = 1'b0;
  logic [AW-1:0] sa0_a = '0, sa1_a = '0, cf_ag = '0, cf_vi = '0;
  int            sa0_b = 0, sa1_b = 0, cf_b = 0;

  logic [DW-1:0] sram [N];
  op_t           ref_ops [$];

  function automatic logic [DW-1:0] bg_data(input logic [1:0] ps);
    case (ps)
      2'd0:    return 4'b0000;
      2'd1:    return 4'b1111;
      2'd2:    return 4'b0101;
      default: return 4'b1010;
    endcase
  endfunction

  function automatic logic [DW-1:0] rd_fault(input logic [AW-1:0] a, input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    if (sa0_en && a == sa0_a) r[sa0_b] = 1'b0;
    if (sa1_en && a == sa1_a) r[sa1_b] = 1'b1;
    return r;
  endfunction

  // Aggressor bit rising 0->1 flips the victim bit.
  function automatic logic cf_fire(input logic [AW-1:0] a, input logic [DW-1:0] old_v, input logic [DW-1:0] new_v);
    return cf_en && (a == cf_ag) && !old_v[cf_b] && new_v[cf_b];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) sram[i] <= 4'($urandom);
      bus.mem_rdata <= '0;
    end else if (bus.mem_ce) begin
      if (bus.mem_we) begin
        if (cf_fire(bus.mem_addr, sram[bus.mem_addr], bg_data(bus.pat_sel)))
          sram[cf_vi][cf_b] <= ~sram[cf_vi][cf_b];
        sram[bus.mem_addr] <= bg_data(bus.pat_sel);
      end else begin
        bus.mem_rdata <= rd_fault(bus.mem_addr, sram[bus.mem_addr]);
      end
    end
  end

  task automatic build_ref();
    int el_len  [6] = '{1, 2, 2, 2, 2, 1};
    int el_down [6] = '{0, 0, 0, 1, 1, 1};
    int el_we0  [6] = '{1, 0, 0, 0, 0, 0};
    int el_v0   [6] = '{0, 0, 1, 0, 1, 0};
    int el_v1   [6] = '{0, 1, 0, 1, 0, 0};
    op_t op;
    ref_ops.delete();
    for (int bg = 0; bg < 2; bg++)
      for (int e = 0; e < 6; e++)
        for (int k = 0; k < N; k++)
          for (int o = 0; o < el_len[e]; o++) begin
            op.a  = AW'(el_down[e] != 0 ? N - 1 - k : k);
            op.we = (o == 1) ? 1'b1 : 1'(el_we0[e]);
            op.ps = {1'(bg), 1'(o == 1 ? el_v1[e] : el_v0[e])};
            ref_ops.push_back(op);
          end
  endtask

  task automatic ref_result(output logic f, output logic [AW-1:0] fa);
    logic [DW-1:0] m [N];
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) m[i] = '0;
    f = 1'b0;
    fa = '0;
    foreach (ref_ops[i]) begin
      d = bg_data(ref_ops[i].ps);
      if (ref_ops[i].we) begin
        if (cf_fire(ref_ops[i].a, m[ref_ops[i].a], d)) m[cf_vi][cf_b] = ~m[cf_vi][cf_b];
        m[ref_ops[i].a] = d;
      end else if (rd_fault(ref_ops[i].a, m[ref_ops[i].a]) != d && !f) begin
        f = 1'b1;
        fa = ref_ops[i].a;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.busy, bus.done, bus.fail, bus.fail_addr, bus.mem_addr, bus.mem_ce, bus.mem_we, bus.pat_sel};
  endfunction

  task automatic run_test(input string nm, input int spur_cyc, input int abort_cyc, input bit spot);
    logic          ef;
    logic [AW-1:0] efa;
    int cyc, busy_n, ce_n, bad;
    ref_result(ef, efa);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    cyc = 1; busy_n = 0; ce_n = 0; bad = 0;
    chk({nm, ":c1_state"}, {bus.busy, bus.done, bus.fail, bus.fail_addr}, {1'b1, 1'b0, 1'b0, 8'h00});
    while (bus.busy && cyc <= 6000) begin
      busy_n++;
      if (bus.mem_ce) ce_n++;
      if (cyc <= 20 * N) begin
        if (!bus.mem_ce || {bus.mem_addr, bus.mem_we, bus.pat_sel} !== ref_ops[cyc-1]) bad++;
      end else if (bus.mem_ce || bus.pat_sel != 2'b00) begin
        bad++;
      end
      if (spot) begin
        case (cyc)
          1:    chk("spot_c1",    {bus.mem_addr, bus.mem_we, bus.pat_sel}, {8'h00, 1'b1, 2'b00});
          256:  chk("spot_c256",  {bus.mem_addr, bus.mem_we, bus.pat_sel}, {8'hFF, 1'b1, 2'b00});
          257:  chk("spot_c257",  {bus.mem_addr, bus.mem_we, bus.pat_sel}, {8'h00, 1'b0, 2'b00});
          258:  chk("spot_c258",  {bus.mem_addr, bus.mem_we, bus.pat_sel}, {8'h00, 1'b1, 2'b01});
          1281: chk("spot_m3",    {bus.mem_addr, bus.mem_we, bus.pat_sel}, {8'hFF, 1'b0, 2'b00});
          2561: chk("spot_bg1",   {bus.mem_addr, bus.mem_we, bus.pat_sel}, {8'h00, 1'b1, 2'b10});
          default: ;
        endcase
      end
      if (cyc == abort_cyc) begin
        rst_n = 1'b0;
        #1;
        chk({nm, ":async_reset_outs"}, all_outs(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({nm, ":idle_after_reset"}, all_outs(), 32'h0);
        return;
      end
      bus.start = (cyc == spur_cyc);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk({nm, ":busy_cycles"}, busy_n, 20 * N + 1);
    chk({nm, ":ce_cycles"}, ce_n, 20 * N);
    chk({nm, ":op_seq_bad"}, bad, 0);
    chk({nm, ":done"}, bus.done, 1'b1);
    chk({nm, ":fail"}, bus.fail, ef);
    chk({nm, ":fail_addr"}, bus.fail_addr, efa);
    chk({nm, ":idle_bus"}, {bus.mem_ce, bus.pat_sel}, 3'b000);
  endtask

  task automatic clear_faults();
    sa0_en = 1'b0;
    sa1_en = 1'b0;
    cf_en  = 1'b0;
  endtask

  initial begin
    int kind;
    bus.start = 1'b0;
    build_ref();
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", all_outs(), 32'h0);

    run_test("clean_spur", 1000, -1, 1'b1);

    sa0_en = 1'b1; sa0_a = 8'h3C; sa0_b = 2;
    sa1_en = 1'b1; sa1_a = 8'hA0; sa1_b = int'($urandom_range(0, 3));
    run_test("stuck", -1, -1, 1'b0);

    clear_faults();
    cf_en = 1'b1; cf_ag = 8'h10; cf_vi = 8'h11; cf_b = 0;
    run_test("coupling", -1, -1, 1'b0);

    clear_faults();
    run_test("abort", -1, 2000, 1'b0);
    run_test("after_reset", -1, -1, 1'b0);

    for (int r = 0; r < 2; r++) begin
      clear_faults();
      kind = int'($urandom_range(0, 2));
      if (kind == 0) begin
        sa0_en = 1'b1; sa0_a = AW'($urandom); sa0_b = int'($urandom_range(0, 3));
      end else if (kind == 1) begin
        sa1_en = 1'b1; sa1_a = AW'($urandom); sa1_b = int'($urandom_range(0, 3));
      end else begin
        cf_en = 1'b1; cf_ag = AW'($urandom); cf_b = int'($urandom_range(0, 3));
        cf_vi = cf_ag + AW'($urandom_range(1, N - 1));
      end
      run_test($sformatf("rand%0d_k%0d", r, kind), -1, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
